// File: rtl/drive_bank_sequencer.sv
// -----------------------------------------------------------------------------
// drive_bank_sequencer
//
// Sequences the per-slice enables of a bank of parallel buffer drivers that
// share one output net. It switches slices on or off one at a time, with a
// programmable interval between toggles, so that inrush current and supply
// droop stay limited. It ramps up on req_on and down on req_off. ack pulses
// for one cycle when a ramp completes.
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   reset        : synchronous, active-high reset
//   req_on       : level request to ramp the bank up
//   req_off      : level request to ramp the bank down
//   step_cycles  : cycles between successive slice toggles (0 acts as 1)
//   bank_en      : thermometer-coded slice enables; bit 0 is the first on and
//                  the last off
//   busy         : high while ramping up or down
//   ack          : one-cycle pulse on the edge a ramp completes
//   state        : OFF=0, RAMP_UP=1, ON=2, RAMP_DOWN=3
// -----------------------------------------------------------------------------
module drive_bank_sequencer #(
    parameter int NBANKS = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_on,
    input  logic              req_off,
    input  logic [CNT_W-1:0]  step_cycles,
    output logic [NBANKS-1:0] bank_en,
    output logic              busy,
    output logic              ack,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [NBANKS-1:0] BANK_ZERO = {NBANKS{1'b0}};
    localparam logic [NBANKS-1:0] BANK_ALL  = {NBANKS{1'b1}};
    localparam logic [NBANKS-1:0] BANK_LSB  = NBANKS'(1);
    localparam logic [CNT_W-1:0]  TMR_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  TMR_ONE   = CNT_W'(1);

    // Add one more enabled slice on top of a thermometer code. Written as a
    // shift-and-or so that it also holds for a single-slice bank.
    function automatic logic [NBANKS-1:0] shift_up(input logic [NBANKS-1:0] v);
        return (v << 1'b1) | BANK_LSB;
    endfunction

    // Drop the topmost enabled slice of a thermometer code.
    function automatic logic [NBANKS-1:0] shift_down(input logic [NBANKS-1:0] v);
        return v >> 1'b1;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [NBANKS-1:0]   bank_r;
    logic [NBANKS-1:0]   bank_nxt_s;
    logic [CNT_W-1:0]    timer_r;
    logic [CNT_W-1:0]    timer_nxt_s;
    logic                ack_r;
    logic                ack_nxt_s;
    logic                busy_r;

    logic                on_only_s;
    logic                off_only_s;
    logic [CNT_W-1:0]    step_val_s;
    logic [NBANKS-1:0]   up_bank_s;
    logic [NBANKS-1:0]   down_bank_s;
    logic                timer_exp_s;

    // Both requests together are a no-op, so only a lone request acts.
    assign on_only_s   = req_on & ~req_off;
    assign off_only_s  = req_off & ~req_on;
    // The interval is sampled at every reload, never latched per ramp.
    assign step_val_s  = (step_cycles == TMR_ZERO) ? TMR_ONE : step_cycles;
    assign up_bank_s   = shift_up(bank_r);
    assign down_bank_s = shift_down(bank_r);
    // A timer of 0 inside a ramp is unreachable. It is treated as expired so
    // that the counter can never wrap around.
    assign timer_exp_s = (timer_r <= TMR_ONE);

    // Next-state, next-enable, timer and ack decode.
    always_comb begin
        state_nxt_s = state_r;
        bank_nxt_s  = bank_r;
        timer_nxt_s = timer_r;
        ack_nxt_s   = 1'b0;
        case (state_r)
            ST_OFF: begin
                timer_nxt_s = TMR_ZERO;
                if (on_only_s) begin
                    bank_nxt_s = up_bank_s;
                    // A single-slice bank is full after its first step.
                    if (up_bank_s == BANK_ALL) begin
                        state_nxt_s = ST_ON;
                        ack_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_RAMP_UP;
                        timer_nxt_s = step_val_s;
                    end
                end else begin
                    bank_nxt_s = bank_r;
                end
            end
            ST_RAMP_UP: begin
                if (off_only_s) begin
                    // A reversal takes priority over a same-edge expiry.
                    bank_nxt_s = down_bank_s;
                    if (down_bank_s == BANK_ZERO) begin
                        state_nxt_s = ST_OFF;
                        timer_nxt_s = TMR_ZERO;
                        ack_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_RAMP_DOWN;
                        timer_nxt_s = step_val_s;
                    end
                end else if (timer_exp_s) begin
                    bank_nxt_s = up_bank_s;
                    if (up_bank_s == BANK_ALL) begin
                        state_nxt_s = ST_ON;
                        timer_nxt_s = TMR_ZERO;
                        ack_nxt_s   = 1'b1;
                    end else begin
                        timer_nxt_s = step_val_s;
                    end
                end else begin
                    timer_nxt_s = timer_r - TMR_ONE;
                end
            end
            ST_ON: begin
                timer_nxt_s = TMR_ZERO;
                if (off_only_s) begin
                    bank_nxt_s = down_bank_s;
                    if (down_bank_s == BANK_ZERO) begin
                        state_nxt_s = ST_OFF;
                        ack_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_RAMP_DOWN;
                        timer_nxt_s = step_val_s;
                    end
                end else begin
                    bank_nxt_s = bank_r;
                end
            end
            ST_RAMP_DOWN: begin
                if (on_only_s) begin
                    bank_nxt_s = up_bank_s;
                    if (up_bank_s == BANK_ALL) begin
                        state_nxt_s = ST_ON;
                        timer_nxt_s = TMR_ZERO;
                        ack_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_RAMP_UP;
                        timer_nxt_s = step_val_s;
                    end
                end else if (timer_exp_s) begin
                    bank_nxt_s = down_bank_s;
                    if (down_bank_s == BANK_ZERO) begin
                        state_nxt_s = ST_OFF;
                        timer_nxt_s = TMR_ZERO;
                        ack_nxt_s   = 1'b1;
                    end else begin
                        timer_nxt_s = step_val_s;
                    end
                end else begin
                    timer_nxt_s = timer_r - TMR_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_OFF;
                bank_nxt_s  = BANK_ZERO;
                timer_nxt_s = TMR_ZERO;
                ack_nxt_s   = 1'b0;
            end
        endcase
    end

    // State, enable, timer and output registers. Reset drops every slice at
    // once with no staged shutdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_OFF;
            bank_r  <= BANK_ZERO;
            timer_r <= TMR_ZERO;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            bank_r  <= bank_nxt_s;
            timer_r <= timer_nxt_s;
            ack_r   <= ack_nxt_s;
            // busy is decoded from the next state so that it lines up with
            // the registered state output.
            busy_r  <= (state_nxt_s == ST_RAMP_UP) || (state_nxt_s == ST_RAMP_DOWN);
        end
    end

    assign bank_en = bank_r;
    assign busy    = busy_r;
    assign ack     = ack_r;
    assign state   = state_r;

endmodule

// File: tb/tb_drive_bank_sequencer.sv
module tb_drive_bank_sequencer;

    localparam logic [1:0] S_OFF = 2'd0;
    localparam logic [1:0] S_RU  = 2'd1;
    localparam logic [1:0] S_ON  = 2'd2;
    localparam logic [1:0] S_RD  = 2'd3;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       req_on;
    logic       req_off;
    logic [7:0] step_cycles;
    logic [3:0] bank_en;
    logic       busy;
    logic       ack;
    logic [1:0] state;

    logic       req_on1;
    logic       req_off1;
    logic [0:0] bank_en1;
    logic       busy1;
    logic       ack1;
    logic [1:0] state1;

    drive_bank_sequencer #(.NBANKS(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req_on(req_on), .req_off(req_off),
        .step_cycles(step_cycles), .bank_en(bank_en), .busy(busy),
        .ack(ack), .state(state)
    );

    drive_bank_sequencer #(.NBANKS(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .req_on(req_on1), .req_off(req_off1),
        .step_cycles(step_cycles), .bank_en(bank_en1), .busy(busy1),
        .ack(ack1), .state(state1)
    );

    typedef struct {
        logic       rst;
        logic       on;
        logic       off;
        logic [7:0] step;
        logic [3:0] bank;
        logic [1:0] st;
        logic       ack;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [3:0] bank;
        logic [1:0] st;
        logic       ack;
        logic       busy;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic r, input logic on, input logic off,
                                input logic [7:0] s, input logic [3:0] b,
                                input logic [1:0] st, input logic a,
                                input logic bs, input int n);
        vec_t v;
        v.rst = r; v.on = on; v.off = off; v.step = s;
        v.bank = b; v.st = st; v.ack = a; v.busy = bs;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    function automatic logic is_thermo(input logic [3:0] v);
        logic [3:0] t;
        t = v + 4'd1;
        return (t & v) == 4'd0;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        reset       = v.rst;
        req_on      = v.on;
        req_off     = v.off;
        step_cycles = v.step;
        e.bank = v.bank; e.st = v.st; e.ack = v.ack; e.busy = v.busy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty vec=%0d", idx);
        end else begin
            e = exp_q.pop_front();
            if ({bank_en, state, ack, busy} !== {e.bank, e.st, e.ack, e.busy}) begin
                bad++;
                $display("FAIL vec%0d got bank=%b state=%0d ack=%b busy=%b expected bank=%b state=%0d ack=%b busy=%b",
                         idx, bank_en, state, ack, busy, e.bank, e.st, e.ack, e.busy);
            end
        end
        total++;
        if (!is_thermo(bank_en)) begin
            bad++;
            $display("FAIL thermo vec=%0d got bank=%b expected a thermometer code", idx, bank_en);
        end
    endtask

    task automatic check1(input string name, input logic [4:0] got, input logic [4:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got %b expected %b", name, got, expv);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_on = 1'b0; req_off = 1'b0; step_cycles = 8'd3;
        req_on1 = 1'b0; req_off1 = 1'b0;

        // reset
        add(1'b1, 1'b0, 1'b0, 8'd3, 4'b0000, S_OFF, 1'b0, 1'b0, 2);
        // ramp up, S=3, req_on held: slices at edges 0,3,6,9
        add(1'b0, 1'b1, 1'b0, 8'd3, 4'b0001, S_RU,  1'b0, 1'b1, 3);
        add(1'b0, 1'b1, 1'b0, 8'd3, 4'b0011, S_RU,  1'b0, 1'b1, 3);
        add(1'b0, 1'b1, 1'b0, 8'd3, 4'b0111, S_RU,  1'b0, 1'b1, 3);
        add(1'b0, 1'b1, 1'b0, 8'd3, 4'b1111, S_ON,  1'b1, 1'b0, 1);
        add(1'b0, 1'b1, 1'b0, 8'd3, 4'b1111, S_ON,  1'b0, 1'b0, 1);
        // conflicting requests in ON
        add(1'b0, 1'b1, 1'b1, 8'd3, 4'b1111, S_ON,  1'b0, 1'b0, 10);
        // ramp down with step 0 (acts as 1)
        add(1'b0, 1'b0, 1'b1, 8'd0, 4'b0111, S_RD,  1'b0, 1'b1, 1);
        add(1'b0, 1'b0, 1'b1, 8'd0, 4'b0011, S_RD,  1'b0, 1'b1, 1);
        add(1'b0, 1'b0, 1'b1, 8'd0, 4'b0001, S_RD,  1'b0, 1'b1, 1);
        add(1'b0, 1'b0, 1'b1, 8'd0, 4'b0000, S_OFF, 1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, 8'd0, 4'b0000, S_OFF, 1'b0, 1'b0, 1);
        // conflicting requests in OFF
        add(1'b0, 1'b1, 1'b1, 8'd3, 4'b0000, S_OFF, 1'b0, 1'b0, 10);
        // reversal during ramp up
        add(1'b0, 1'b1, 1'b0, 8'd3, 4'b0001, S_RU,  1'b0, 1'b1, 1);
        add(1'b0, 1'b0, 1'b0, 8'd3, 4'b0001, S_RU,  1'b0, 1'b1, 2);
        add(1'b0, 1'b0, 1'b0, 8'd3, 4'b0011, S_RU,  1'b0, 1'b1, 1);
        add(1'b0, 1'b0, 1'b1, 8'd3, 4'b0001, S_RD,  1'b0, 1'b1, 1);
        add(1'b0, 1'b0, 1'b0, 8'd3, 4'b0001, S_RD,  1'b0, 1'b1, 2);
        add(1'b0, 1'b0, 1'b0, 8'd3, 4'b0000, S_OFF, 1'b1, 1'b0, 1);
        // reset mid-ramp, then restart and reverse from a single slice
        add(1'b0, 1'b1, 1'b0, 8'd3, 4'b0001, S_RU,  1'b0, 1'b1, 3);
        add(1'b0, 1'b1, 1'b0, 8'd3, 4'b0011, S_RU,  1'b0, 1'b1, 2);
        add(1'b1, 1'b1, 1'b0, 8'd3, 4'b0000, S_OFF, 1'b0, 1'b0, 1);
        add(1'b0, 1'b1, 1'b0, 8'd3, 4'b0001, S_RU,  1'b0, 1'b1, 1);
        add(1'b0, 1'b0, 1'b1, 8'd3, 4'b0000, S_OFF, 1'b1, 1'b0, 1);
        // live step change 3->1; conflict mid-ramp keeps the timer running
        add(1'b0, 1'b1, 1'b0, 8'd3, 4'b0001, S_RU,  1'b0, 1'b1, 1);
        add(1'b0, 1'b0, 1'b0, 8'd1, 4'b0001, S_RU,  1'b0, 1'b1, 2);
        add(1'b0, 1'b0, 1'b0, 8'd1, 4'b0011, S_RU,  1'b0, 1'b1, 1);
        add(1'b0, 1'b1, 1'b1, 8'd1, 4'b0111, S_RU,  1'b0, 1'b1, 1);
        add(1'b0, 1'b0, 1'b0, 8'd1, 4'b1111, S_ON,  1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b0, 8'd1, 4'b1111, S_ON,  1'b0, 1'b0, 1);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // single-slice bank: complete ramps in one edge
        reset = 1'b1; req_on1 = 1'b0; req_off1 = 1'b0; req_on = 1'b0; req_off = 1'b0;
        @(posedge clk); #1;
        check1("n1_reset", {bank_en1, state1, ack1, busy1}, {1'b0, S_OFF, 1'b0, 1'b0});
        reset = 1'b0; req_on1 = 1'b1;
        @(posedge clk); #1;
        check1("n1_on", {bank_en1, state1, ack1, busy1}, {1'b1, S_ON, 1'b1, 1'b0});
        @(posedge clk); #1;
        check1("n1_on_hold", {bank_en1, state1, ack1, busy1}, {1'b1, S_ON, 1'b0, 1'b0});
        req_on1 = 1'b0; req_off1 = 1'b1;
        @(posedge clk); #1;
        check1("n1_off", {bank_en1, state1, ack1, busy1}, {1'b0, S_OFF, 1'b1, 1'b0});
        @(posedge clk); #1;
        check1("n1_off_hold", {bank_en1, state1, ack1, busy1}, {1'b0, S_OFF, 1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
